noise_generator: RTL and testbench
==================================

Name: noise_generator

Overview:
- Noise channel source for the SN76489-style PSG.
- Produces the 1-bit noise waveform that drives the channel-3 attenuation stage's `in` input. The attenuation control nibble is handled separately.
- Implements the shift-rate divider, white/periodic feedback selection, and the LFSR reset triggered by a write to the noise control register.

Parameters:
- LFSR_BITS, 15, shift-register width.
- TAPS, 15'h0003, white-noise feedback tap mask; feedback is XOR of (lfsr & TAPS).
- SEED, 15'h4000, LFSR load value at reset and on reset_lfsr (MSB set).

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- stb  in  1  clock enable from the master prescaler (one tick = master/16); all shifting and counting advance only when stb=1
- control  in  3  noise register: [2]=FB (1 white, 0 periodic), [1:0]=rate (00→16, 01→32, 10→64 ticks per half-period, 11→tone3)
- reset_lfsr  in  1  one-clk pulse on any write to the noise register
- tone3  in  1  tone channel 3 square output, used when rate=11
- out  out  1  noise waveform = lfsr[0], to the attenuation stage

Behaviour:
- One clock; reset is asynchronous and active-low.
- Reset state (rst_n=0, async):
  - lfsr=SEED, counter=0, toggle=0, tone3_q=0.
  - out=SEED[0]=0.
- stb=0 with no reset_lfsr: all state holds.
- Rate divider, 7-bit down-counter, on stb:
  - If counter<=1: counter<=reload(rate) and toggle<=~toggle.
  - Else: counter<=counter-1.
  - Result: 16/32/64 ticks per half-period, so one shift every 32/64/128 ticks.
  - After reset, the first stb reloads and raises toggle.
  - A rate change takes effect at the next reload.
  - When rate=11 the counter keeps running but its output is ignored.
- Shift event:
  - rate!=11: stb and toggle going 0→1 in that same stb.
  - rate=11: stb and tone3=1 and tone3_q=0.
  - tone3_q<=tone3 on every stb, whatever the rate.
- Shift operation: lfsr<={fb, lfsr[LFSR_BITS-1:1]}.
  - fb = ^(lfsr&TAPS) when FB=1.
  - fb = lfsr[0] when FB=0.
- Latency: out reflects the new lfsr[0] in the clk cycle after the shifting stb cycle. out is a direct register bit with no combinational path from any input.
- reset_lfsr:
  - Synchronous, not gated by stb. lfsr<=SEED.
  - Takes priority over a coincident shift.
  - counter, toggle and tone3_q are unaffected.
- Sequence periods:
  - Periodic: period LFSR_BITS shifts, with out=1 for exactly one shift window.
  - White: period 2^LFSR_BITS-1 shifts.
  - The all-zero state is unreachable from SEED; no lockup handling is needed.
- A control FB change mid-sequence applies from the next shift. It does not reseed the LFSR; the register-write path pulses reset_lfsr.

Decomposition:
- Shared package psg_pkg holds:
  - the noise rate encoding (NOISE_RATE_16/32/64/TONE3) and the reload constants 16/32/64;
  - NOISE_SEED and NOISE_TAPS;
  - the control field bit positions.
- One sub-module: noise_rate_divider, which contains the counter and toggle and outputs a one-cycle rise pulse. The tone generators may later reuse it with a 10-bit reload.

Test Plan:
- Reset: hold rst_n=0 with clk running, then release → out=0, lfsr=0x4000, counter=0, no shift until the first stb.
- Periodic, rate=00, stb=1 every clk:
  - Shift k happens at stb 1+32(k-1).
  - out first rises after shift 14 (stb 417) and falls after shift 15 (stb 449).
  - lfsr is back at 0x4000 after shift 15.
- White, rate=00, FB=1:
  - lfsr=0x0002 after shift 13.
  - After shift 14 lfsr=0x4001, out=1.
  - After shift 15 lfsr=0x6000, out=0.
  - lfsr returns to 0x4000 after exactly 32767 shifts.
- rate=11, tone3 toggled every 10 stbs:
  - One shift per tone3 rising edge only; none on falling edges.
  - None while stb=0, even if tone3 rises and falls between stbs.
- reset_lfsr pulsed in the same cycle as a shift, mid-sequence (lfsr=0x6000) → next cycle lfsr=0x4000, out=0, divider phase unchanged.
- Async reset mid-run: drop rst_n between clk edges while out=1 → out=0 immediately; stb held 0 → state frozen for 100 cycles.

Source files
------------

// File: rtl/psg_pkg.sv
// Shared definitions for the SN76489-style PSG.
// Noise rate encoding, divider reloads, LFSR seed/taps, control fields.
package psg_pkg;

  typedef enum logic [1:0] {
    NOISE_RATE_16    = 2'b00,
    NOISE_RATE_32    = 2'b01,
    NOISE_RATE_64    = 2'b10,
    NOISE_RATE_TONE3 = 2'b11
  } noise_rate_e;

  localparam int NOISE_BITS = 15;
  localparam int NOISE_CW   = 7;

  localparam logic [NOISE_BITS-1:0] NOISE_SEED = 15'h4000;
  localparam logic [NOISE_BITS-1:0] NOISE_TAPS = 15'h0003;

  localparam logic [NOISE_CW-1:0] NOISE_RELOAD_16 = 7'd16;
  localparam logic [NOISE_CW-1:0] NOISE_RELOAD_32 = 7'd32;
  localparam logic [NOISE_CW-1:0] NOISE_RELOAD_64 = 7'd64;

  localparam int CTRL_FB_BIT   = 2;
  localparam int CTRL_RATE_MSB = 1;
  localparam int CTRL_RATE_LSB = 0;

  // Half-period in stb ticks; the tone3 setting keeps the
  // counter running at the fastest rate, its output unused.
  function automatic logic [NOISE_CW-1:0] noise_reload(
    input noise_rate_e rate
  );
    logic [NOISE_CW-1:0] r;
    r = NOISE_RELOAD_16;
    unique case (rate)
      NOISE_RATE_16:    r = NOISE_RELOAD_16;
      NOISE_RATE_32:    r = NOISE_RELOAD_32;
      NOISE_RATE_64:    r = NOISE_RELOAD_64;
      NOISE_RATE_TONE3: r = NOISE_RELOAD_16;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/noise_rate_divider.sv
// Down-counter with half-period toggle; emits a one-cycle pulse
// on each stb where the toggle goes from 0 to 1.
module noise_rate_divider #(
  parameter int CW = 7
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          i_stb,
  input  logic [CW-1:0] i_reload,
  output logic          o_toggle,
  output logic          o_rise
);

  logic [CW-1:0] r_count;
  logic          r_toggle;
  logic          w_expire;

  assign w_expire = (r_count <= CW'(1));
  assign o_toggle = r_toggle;
  assign o_rise   = i_stb & w_expire & ~r_toggle;

  // Count down on stb; reload and flip the toggle on expiry.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count  <= '0;
      r_toggle <= 1'b0;
    end else if (i_stb) begin
      if (w_expire) begin
        r_count  <= i_reload;
        r_toggle <= ~r_toggle;
      end else begin
        r_count  <= r_count - CW'(1);
      end
    end
  end

endmodule

// File: rtl/noise_generator.sv
// PSG noise channel: rate divider, tone3 edge detect and LFSR.
// Output is the LFSR low bit, straight from a register.
module noise_generator
  import psg_pkg::*;
#(
  parameter int                   LFSR_BITS = NOISE_BITS,
  parameter logic [LFSR_BITS-1:0] TAPS      = NOISE_TAPS,
  parameter logic [LFSR_BITS-1:0] SEED      = NOISE_SEED
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       stb,
  input  logic [2:0] control,
  input  logic       reset_lfsr,
  input  logic       tone3,
  output logic       out
);

  noise_rate_e           w_rate;
  logic                  w_white;
  logic [NOISE_CW-1:0]   w_reload;
  logic                  w_div_rise;
  logic                  w_div_toggle;
  logic                  w_tone3_rise;
  logic                  w_shift;
  logic                  w_fb;
  logic [LFSR_BITS-1:0]  r_lfsr;
  logic                  r_tone3_q;

  assign w_rate   = noise_rate_e'(control[CTRL_RATE_MSB:CTRL_RATE_LSB]);
  assign w_white  = control[CTRL_FB_BIT];
  assign w_reload = noise_reload(w_rate);

  noise_rate_divider #(
    .CW (NOISE_CW)
  ) u_div (
    .clk      (clk),
    .rst_n    (rst_n),
    .i_stb    (stb),
    .i_reload (w_reload),
    .o_toggle (w_div_toggle),
    .o_rise   (w_div_rise)
  );

  assign w_tone3_rise = stb & tone3 & ~r_tone3_q;

  // Pick the shift source: divider rise or tone3 rising edge.
  always_comb begin
    w_shift = w_div_rise;
    if (w_rate == NOISE_RATE_TONE3) begin
      w_shift = w_tone3_rise;
    end
  end

  // White noise XORs the tapped bits; periodic recirculates bit 0.
  always_comb begin
    w_fb = r_lfsr[0];
    if (w_white) begin
      w_fb = ^(r_lfsr & TAPS);
    end
  end

  // Tone3 sample for edge detection, advanced on stb only.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_tone3_q <= 1'b0;
    end else if (stb) begin
      r_tone3_q <= tone3;
    end
  end

  // LFSR: reseed on register write wins over a coincident shift.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_lfsr <= SEED;
    end else if (reset_lfsr) begin
      r_lfsr <= SEED;
    end else if (w_shift) begin
      r_lfsr <= {w_fb, r_lfsr[LFSR_BITS-1:1]};
    end
  end

  assign out = r_lfsr[0];

endmodule

// File: tb/tb_noise_generator.sv
// Self-checking bench for noise_generator.
// Vector table, corner sequences and a randomized model comparison.
module tb_noise_generator;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       stb = 1'b0;
  logic [2:0] control = 3'b000;
  logic       reset_lfsr = 1'b0;
  logic       tone3 = 1'b0;
  logic       out;

  noise_generator dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .stb        (stb),
    .control    (control),
    .reset_lfsr (reset_lfsr),
    .tone3      (tone3),
    .out        (out)
  );

  always #5 clk = ~clk;

  int nchk = 0;
  int nfail = 0;
  int n_stb = 0;
  int m_lfsr = 0;

  typedef struct {
    int         idx;
    bit         fb;
    logic       exp_out;
    logic [14:0] exp_lfsr;
  } vec_t;

  vec_t tbl[9];

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    nchk++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    if (stb) n_stb++;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    stb = 1'b0;
    reset_lfsr = 1'b0;
    tone3 = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    n_stb = 0;
    m_lfsr = 'h4000;
  endtask

  // Spec-level next state: shift right, new MSB is bit0 (periodic)
  // or bit0 xor bit1 (white, taps 0x0003).
  function automatic int nxt(input int l, input bit white);
    int b;
    b = white ? ((l ^ (l >> 1)) & 1) : (l & 1);
    return (b << 14) | (l >> 1);
  endfunction

  task automatic advance_to(input int idx);
    int guard;
    guard = 0;
    while (n_stb < idx && guard < 5000) begin
      step();
      guard++;
    end
    if (n_stb != idx) begin
      nchk++;
      nfail++;
      $display("FAIL advance: stb count %0d expected %0d", n_stb, idx);
    end
  endtask

  initial begin
    int exp_l;
    int last_t3;
    int shifts;
    int rate;
    int per;
    bit fb;
    bit sh;

    tbl[0] = '{1,   1'b0, 1'b0, 15'h2000};
    tbl[1] = '{416, 1'b0, 1'b0, 15'h0002};
    tbl[2] = '{417, 1'b0, 1'b1, 15'h0001};
    tbl[3] = '{448, 1'b0, 1'b1, 15'h0001};
    tbl[4] = '{449, 1'b0, 1'b0, 15'h4000};
    tbl[5] = '{1,   1'b1, 1'b0, 15'h2000};
    tbl[6] = '{385, 1'b1, 1'b0, 15'h0002};
    tbl[7] = '{417, 1'b1, 1'b1, 15'h4001};
    tbl[8] = '{449, 1'b1, 1'b0, 15'h6000};

    // Reset state, no shift while stb stays low
    do_reset();
    repeat (5) step();
    chk("rst_out", 32'(out), 32'd0);
    chk("rst_lfsr", 32'(dut.r_lfsr), 32'h4000);
    chk("rst_cnt", 32'(dut.u_div.r_count), 32'd0);

    // Table: periodic and white sequences at rate 16, stb every clk
    for (int i = 0; i < 9; i++) begin
      if (i == 0 || tbl[i].fb != tbl[i-1].fb) begin
        do_reset();
        control = {tbl[i].fb, 2'b00};
        stb = 1'b1;
      end
      advance_to(tbl[i].idx);
      chk($sformatf("tbl%0d_out", i), 32'(out), 32'(tbl[i].exp_out));
      chk($sformatf("tbl%0d_lfsr", i), 32'(dut.r_lfsr),
          32'(tbl[i].exp_lfsr));
    end

    // reset_lfsr coincident with shift 16 (lfsr=0x6000)
    advance_to(480);
    chk("pre_rl_lfsr", 32'(dut.r_lfsr), 32'h6000);
    reset_lfsr = 1'b1;
    step();
    reset_lfsr = 1'b0;
    chk("rl_lfsr", 32'(dut.r_lfsr), 32'h4000);
    chk("rl_out", 32'(out), 32'd0);
    advance_to(512);
    chk("rl_hold", 32'(dut.r_lfsr), 32'h4000);
    step();
    chk("rl_phase", 32'(dut.r_lfsr), 32'h2000);

    // Async reset mid-run while out=1, then frozen with stb=0
    do_reset();
    control = 3'b000;
    stb = 1'b1;
    advance_to(417);
    chk("ar_pre_out", 32'(out), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("ar_out", 32'(out), 32'd0);
    stb = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (100) step();
    chk("ar_frz_lfsr", 32'(dut.r_lfsr), 32'h4000);
    chk("ar_frz_cnt", 32'(dut.u_div.r_count), 32'd0);
    chk("ar_frz_out", 32'(out), 32'd0);
    stb = 1'b1;
    step();
    chk("ar_first", 32'(dut.r_lfsr), 32'h2000);

    // tone3 mode: toggle every 10 stbs, shift on rising edges only
    do_reset();
    control = 3'b011;
    stb = 1'b1;
    exp_l = 'h4000;
    last_t3 = 0;
    shifts = 0;
    for (int j = 0; j < 200; j++) begin
      tone3 = ((j / 10) % 2) != 0;
      step();
      if (tone3 && last_t3 == 0) begin
        exp_l = nxt(exp_l, 1'b0);
        shifts++;
      end
      last_t3 = int'(tone3);
    end
    chk("t3_shifts", 32'(shifts), 32'd10);
    chk("t3_lfsr", 32'(dut.r_lfsr), 32'(exp_l));
    stb = 1'b0;
    tone3 = 1'b0;
    step();
    tone3 = 1'b1;
    step();
    tone3 = 1'b0;
    step();
    stb = 1'b1;
    step();
    step();
    chk("t3_nostb", 32'(dut.r_lfsr), 32'(exp_l));

    // Randomized: fixed rate per segment, random stb/tone3/fb/reseed
    for (int seg = 0; seg < 6; seg++) begin
      do_reset();
      rate = (seg < 4) ? seg : int'($urandom_range(0, 3));
      fb = 1'($urandom);
      control = {fb, 2'(rate)};
      per = 2 * (16 << rate);
      last_t3 = 0;
      for (int c = 0; c < 3000; c++) begin
        stb = ($urandom % 4) != 0;
        if ($urandom % 3 == 0) tone3 = ~tone3;
        reset_lfsr = ($urandom % 150) == 0;
        if ($urandom % 400 == 0) control[2] = ~control[2];
        step();
        if (rate == 3)
          sh = stb && tone3 && last_t3 == 0;
        else
          sh = stb && ((n_stb - 1) % per == 0);
        if (reset_lfsr)
          m_lfsr = 'h4000;
        else if (sh)
          m_lfsr = nxt(m_lfsr, control[2]);
        if (stb) last_t3 = int'(tone3);
        chk($sformatf("rnd%0d_lfsr", seg), 32'(dut.r_lfsr),
            32'(m_lfsr));
        chk($sformatf("rnd%0d_out", seg), 32'(out),
            32'(m_lfsr & 1));
      end
      reset_lfsr = 1'b0;
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             nchk, nfail);
    $finish;
  end

endmodule
